// File: rtl/arinc429_rx_if.sv
// Signal bundle between an ARINC 429 receive channel's control/buffer logic and its line decoder.
// The SDI filter ports exist only when ARINC_RX_SDI_FILTER_EN is defined.
interface arinc429_rx_if;
`ifdef ARINC_RX_SDI_FILTER_EN
    logic        sdi_check;
    logic [1:0]  sdi_value;
`endif
    logic        enable;
    logic        rate_sel;
    logic        parity_en;
    logic        InputA;
    logic        InputB;
    logic [31:0] word_data;
    logic        word_valid;
    logic        err_parity;
    logic        err_bitlen;
    logic        err_gap;
    logic        err_line;
    logic        synced;

    modport master (
`ifdef ARINC_RX_SDI_FILTER_EN
        output sdi_check, sdi_value,
`endif
        output enable, rate_sel, parity_en, InputA, InputB,
        input  word_data, word_valid, err_parity, err_bitlen, err_gap, err_line, synced
    );

    modport slave (
`ifdef ARINC_RX_SDI_FILTER_EN
        input  sdi_check, sdi_value,
`endif
        input  enable, rate_sel, parity_en, InputA, InputB,
        output word_data, word_valid, err_parity, err_bitlen, err_gap, err_line, synced
    );
endinterface

// File: rtl/arinc429_rx_decoder.sv
// ARINC 429 bipolar line decoder: recovers bit timing from pulse/NULL durations and assembles 32-bit words.
// Optional SDI filtering of completed words is enabled by defining ARINC_RX_SDI_FILTER_EN.
module arinc429_rx_decoder #(
    parameter int INPUTFREQUENCY = 62_500_000,
    parameter int CNT_W          = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    arinc429_rx_if.slave  bus
);
    localparam int T_HI = INPUTFREQUENCY / 100_000;
    localparam int T_LO = INPUTFREQUENCY / 12_500;

    localparam logic [CNT_W:0] SYNC_THR_HI = (CNT_W+1)'(2 * T_HI);
    localparam logic [CNT_W:0] SYNC_THR_LO = (CNT_W+1)'(2 * T_LO);
    localparam logic [CNT_W:0] GAP_THR_HI  = (CNT_W+1)'(T_HI);
    localparam logic [CNT_W:0] GAP_THR_LO  = (CNT_W+1)'(T_LO);
    localparam logic [CNT_W:0] WMIN_HI     = (CNT_W+1)'(T_HI / 4);
    localparam logic [CNT_W:0] WMIN_LO     = (CNT_W+1)'(T_LO / 4);
    localparam logic [CNT_W:0] WMAX_HI     = (CNT_W+1)'((3 * T_HI) / 4);
    localparam logic [CNT_W:0] WMAX_LO     = (CNT_W+1)'((3 * T_LO) / 4);

    typedef enum logic [1:0] {SYNC, GAP, PULSE} state_t;
    typedef enum logic [1:0] {L_NULL = 2'b00, L_LO = 2'b01, L_HI = 2'b10, L_BAD = 2'b11} line_t;

    // Two-stage synchronisers: index 1 is line A, index 0 is line B
    logic [1:0] raw_line;
    logic [1:0] sync_line;
    assign raw_line = {bus.InputA, bus.InputB};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic [1:0] ff_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) ff_q <= 2'b00;
                else          ff_q <= {ff_q[0], raw_line[gi]};
            end
            assign sync_line[gi] = ff_q[1];
        end
    endgenerate

    line_t             line_now;
    line_t             line_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W:0]    dur;
    logic [CNT_W:0]    width;
    assign line_now = line_t'(sync_line);

    // dur: cycles the current line state has been present, including this one
    assign dur   = (line_now != line_q) ? (CNT_W+1)'(1) : {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign width = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q <= L_NULL;
            cnt_q  <= '0;
        end else begin
            line_q <= line_now;
            if (!bus.enable || line_now != line_q) cnt_q <= '0;
            else if (cnt_q != {CNT_W{1'b1}})       cnt_q <= cnt_q + 1'b1;
        end
    end

    state_t      state_q, state_d;
    logic [4:0]  bit_idx_q, bit_idx_d;
    logic [31:0] shift_q, shift_d;
    logic        rate_q, par_q;
    logic        rate_cur;
    logic [CNT_W:0] sync_thr, gap_thr, wmin, wmax;

    // Rate/parity settings are sampled continuously in SYNC and frozen for the word
    assign rate_cur = (state_q == SYNC) ? bus.rate_sel : rate_q;
    assign sync_thr = rate_cur ? SYNC_THR_LO : SYNC_THR_HI;
    assign gap_thr  = rate_cur ? GAP_THR_LO  : GAP_THR_HI;
    assign wmin     = rate_cur ? WMIN_LO     : WMIN_HI;
    assign wmax     = rate_cur ? WMAX_LO     : WMAX_HI;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SYNC;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rate_q    <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            if (state_q == SYNC) begin
                rate_q <= bus.rate_sel;
                par_q  <= bus.parity_en;
            end
        end
    end

    logic ev_word, ev_bitlen, ev_gap, ev_line;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        ev_word   = 1'b0;
        ev_bitlen = 1'b0;
        ev_gap    = 1'b0;
        ev_line   = 1'b0;
        if (!bus.enable) begin
            state_d   = SYNC;
            bit_idx_d = '0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (line_now == L_NULL && dur >= sync_thr) begin
                        state_d   = GAP;
                        bit_idx_d = '0;
                    end
                end
                GAP: begin
                    case (line_now)
                        L_HI, L_LO: state_d = PULSE;
                        L_BAD: begin
                            ev_line = 1'b1;
                            state_d = SYNC;
                        end
                        default: begin
                            if (bit_idx_q != 5'd0 && dur > gap_thr) begin
                                ev_gap  = 1'b1;
                                state_d = SYNC;
                            end
                        end
                    endcase
                end
                PULSE: begin
                    if (line_now != line_q) begin
                        state_d = SYNC;
                        case (line_now)
                            L_NULL: begin
                                if (width >= wmin && width <= wmax) begin
                                    shift_d[bit_idx_q] = (line_q == L_HI);
                                    bit_idx_d          = bit_idx_q + 5'd1;
                                    ev_word            = (bit_idx_q == 5'd31);
                                    state_d            = GAP;
                                end else begin
                                    ev_bitlen = 1'b1;
                                end
                            end
                            L_BAD:   ev_line   = 1'b1;
                            default: ev_bitlen = 1'b1;
                        endcase
                    end
                end
                default: state_d = SYNC;
            endcase
            if (state_d == SYNC) bit_idx_d = '0;
        end
    end

    logic        drop;
    logic        word_valid_d, err_parity_d;
    logic [31:0] word_data_d;
    logic        word_valid_q, err_parity_q, err_bitlen_q, err_gap_q, err_line_q;
    logic [31:0] word_data_q;

`ifdef ARINC_RX_SDI_FILTER_EN
    assign drop = bus.sdi_check && (shift_d[9:8] != bus.sdi_value);
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        word_valid_d = ev_word && !drop;
        err_parity_d = word_valid_d && par_q && !(^shift_d);
        word_data_d  = word_valid_d ? shift_d : word_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_valid_q <= 1'b0;
            err_parity_q <= 1'b0;
            err_bitlen_q <= 1'b0;
            err_gap_q    <= 1'b0;
            err_line_q   <= 1'b0;
            word_data_q  <= '0;
        end else begin
            word_valid_q <= word_valid_d;
            err_parity_q <= err_parity_d;
            err_bitlen_q <= ev_bitlen;
            err_gap_q    <= ev_gap;
            err_line_q   <= ev_line;
            word_data_q  <= word_data_d;
        end
    end

    assign bus.word_valid = word_valid_q;
    assign bus.err_parity = err_parity_q;
    assign bus.err_bitlen = err_bitlen_q;
    assign bus.err_gap    = err_gap_q;
    assign bus.err_line   = err_line_q;
    assign bus.word_data  = word_data_q;
    assign bus.synced     = (state_q != SYNC);
endmodule

// File: tb/tb_arinc429_rx_decoder.sv
// Directed bench for arinc429_rx_decoder at a scaled clock (6.4 MHz: T_HI = 64, T_LO = 512 clocks).
// Tolerances: 100k pulse 16..48, gap limit 64, sync 128; 12.5k pulse 128..384, gap 512, sync 1024.
module tb_arinc429_rx_decoder;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    arinc429_rx_if bus();

    arinc429_rx_decoder #(.INPUTFREQUENCY(6_400_000), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_valid = 0, n_bitlen = 0, n_gap = 0, n_line = 0;
    logic [31:0] last_data = '0;
    logic        last_par = 1'b0;
    int          vld_cyc = 0, prev_vld_cyc = 0, fall_cyc = 0;
    logic        multi = 1'b0;

    always @(negedge clk) begin
        if (bus.word_valid === 1'b1) begin
            n_valid++;
            last_data    = bus.word_data;
            last_par     = bus.err_parity;
            prev_vld_cyc = vld_cyc;
            vld_cyc      = cyc;
            $display("word: data=%08h err_parity=%0b cyc=%0d", bus.word_data, bus.err_parity, cyc);
        end
        if (bus.err_bitlen === 1'b1) n_bitlen++;
        if (bus.err_gap === 1'b1)    n_gap++;
        if (bus.err_line === 1'b1)   n_line++;
        if ($countones({bus.word_valid, bus.err_bitlen, bus.err_gap, bus.err_line}) > 1) multi = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.InputA = 1'b0;
        bus.InputB = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic v, input int pw, input int nw);
        bus.InputA = v;
        bus.InputB = ~v;
        repeat (pw) @(negedge clk);
        bus.InputA = 1'b0;
        bus.InputB = 1'b0;
        fall_cyc   = cyc;
        repeat (nw) @(negedge clk);
    endtask

    // even-indexed bits use pulse width pwa, odd-indexed bits pwb
    task automatic send_bits(input logic [31:0] w, input int first, input int last,
                             input int pwa, input int pwb, input int nw);
        for (int i = first; i <= last; i++)
            pulse(w[i], (i % 2 == 1) ? pwb : pwa, nw);
    endtask

    int nv, nb, ng, nl;
    logic [31:0] word1;

    initial begin
        bus.enable    = 1'b0;
        bus.rate_sel  = 1'b0;
        bus.parity_en = 1'b1;
        bus.InputA    = 1'b0;
        bus.InputB    = 1'b0;
`ifdef ARINC_RX_SDI_FILTER_EN
        bus.sdi_check = 1'b0;
        bus.sdi_value = 2'b00;
`endif
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_word_valid", bus.word_valid, 0);
        chk("rst_word_data", bus.word_data, 0);
        chk("rst_synced", bus.synced, 0);
        chk("rst_err_line", bus.err_line, 0);
        reset_n    = 1'b1;
        bus.enable = 1'b1;

        idle(192);
        chk("sync_after_null", bus.synced, 1);

        // even parity word -> err_parity
        nv = n_valid;
        send_bits(32'h8000_0001, 0, 31, 32, 32, 32);
        chk("w1_count", n_valid - nv, 1);
        chk("w1_data", last_data, 32'h8000_0001);
        chk("w1_parity", last_par, 1);
        chk("w1_latency", vld_cyc - fall_cyc, 3);

        nv = n_valid;
        send_bits(32'h8000_0003, 0, 31, 32, 32, 32);
        chk("w2_count", n_valid - nv, 1);
        chk("w2_data", last_data, 32'h8000_0003);
        chk("w2_parity", last_par, 0);

        // back-to-back with rate_sel toggled mid-word: both still at 100k
        nv = n_valid;
        send_bits(32'h0F0F_1234, 0, 5, 32, 32, 32);
        bus.rate_sel = 1'b1;
        send_bits(32'h0F0F_1234, 6, 31, 32, 32, 32);
        word1 = last_data;
        chk("b2b_w1_data", word1, 32'h0F0F_1234);
        idle(256);
        send_bits(32'h5555_AAAA, 0, 31, 32, 32, 32);
        chk("b2b_count", n_valid - nv, 2);
        chk("b2b_w2_data", last_data, 32'h5555_AAAA);
        chk("b2b_w2_parity", last_par, 1);
        chk("b2b_interval", vld_cyc - prev_vld_cyc, 32 * 64 + 256);

        // resync at 12.5k; pulses at both tolerance bounds
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("disabled_synced", bus.synced, 0);
        bus.enable = 1'b1;
        idle(1100);
        chk("lo_synced", bus.synced, 1);
        nv = n_valid;
        send_bits(32'h1234_5678, 0, 31, 128, 384, 128);
        chk("lo_count", n_valid - nv, 1);
        chk("lo_data", last_data, 32'h1234_5678);
        chk("lo_parity", last_par, 0);

        nb = n_bitlen; nv = n_valid;
        pulse(1'b1, 127, 20);
        chk("short_bitlen", n_bitlen - nb, 1);
        chk("short_no_word", n_valid - nv, 0);
        chk("short_synced", bus.synced, 0);

        // back to 100k; direct HI->LO transition
        bus.rate_sel = 1'b0;
        idle(200);
        chk("hi_resync", bus.synced, 1);
        nb = n_bitlen;
        bus.InputA = 1'b1; bus.InputB = 1'b0;
        repeat (32) @(negedge clk);
        bus.InputA = 1'b0; bus.InputB = 1'b1;
        repeat (32) @(negedge clk);
        idle(10);
        chk("hilo_bitlen", n_bitlen - nb, 1);
        chk("hilo_synced", bus.synced, 0);
        idle(200);

        // mid-word gap of 70 clocks after bit 10, extended to 140 -> resync
        ng = n_gap; nv = n_valid;
        send_bits(32'h0000_07FF, 0, 10, 32, 32, 32);
        idle(38);
        chk("gap_err", n_gap - ng, 1);
        chk("gap_synced", bus.synced, 0);
        idle(70);
        chk("gap_resync", bus.synced, 1);
        send_bits(32'hA5A5_0F0F, 0, 31, 32, 32, 32);
        chk("gap_count", n_valid - nv, 1);
        chk("gap_next_data", last_data, 32'hA5A5_0F0F);
        chk("gap_next_parity", last_par, 1);

        // A = B = 1 mid-word
        nl = n_line;
        send_bits(32'h0000_001F, 0, 4, 32, 32, 32);
        bus.InputA = 1'b1; bus.InputB = 1'b1;
        repeat (5) @(negedge clk);
        idle(10);
        chk("line_err", n_line - nl, 1);
        chk("line_data_kept", bus.word_data, 32'hA5A5_0F0F);
        chk("line_synced", bus.synced, 0);
        idle(200);

`ifdef ARINC_RX_SDI_FILTER_EN
        bus.sdi_check = 1'b1;
        bus.sdi_value = 2'b01;
        nv = n_valid;
        send_bits(32'h0000_0155, 0, 31, 32, 32, 32);
        chk("sdi_match_count", n_valid - nv, 1);
        chk("sdi_match_data", last_data, 32'h0000_0155);
        send_bits(32'h0000_0255, 0, 31, 32, 32, 32);
        chk("sdi_drop_count", n_valid - nv, 1);
        chk("sdi_drop_data", bus.word_data, 32'h0000_0155);
        bus.sdi_check = 1'b0;
`endif

        chk("exclusive_strobes", multi, 0);

        // reset asserted in the middle of a pulse
        send_bits(32'h0000_03FF, 0, 8, 32, 32, 32);
        bus.InputA = 1'b1; bus.InputB = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_word_data", bus.word_data, 0);
        chk("midrst_word_valid", bus.word_valid, 0);
        chk("midrst_synced", bus.synced, 0);
        chk("midrst_errs", {bus.err_parity, bus.err_bitlen, bus.err_gap, bus.err_line}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
